// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and sizing constants for the memory responder
package mem_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, HI, LO, RESP} state_t;
  localparam int WORD_BYTES = 2;
  localparam int MEM_DEPTH = 16384;
endpackage

// File: rtl/mem_responder_byte_ram.sv
// byte_ram: single-port synchronous 8-bit RAM with registered read data
//   clock: rising-edge clock; we: write enable; addr: byte address
//   wdata: byte to write; rdata: byte at addr, registered (read-before-write)
module byte_ram #(
  parameter int DEPTH = 16384,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: 16-bit word read/write responder over a big-endian byte RAM
//   clock, reset_n: rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready: request handshake; req_write, req_addr, req_wdata: request
//   resp_valid/resp_ready: response handshake; resp_rdata, resp_error: response
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_error
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [16:0] LAST = 17'(DEPTH - WORD_BYTES);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0] hi_q, hi_d;
  logic rd_q, rd_d;
  logic err_q, err_d;
  logic ready_q, ready_d;
  logic valid_q, valid_d;
  logic accept, bad, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  assign accept = req_valid && ready_q;
  assign bad = req_addr[0] || ({1'b0, req_addr} > LAST);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    write_d = write_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    hi_d = hi_q;
    rd_d = rd_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (accept) begin
        write_d = req_write;
        addr_d = req_addr[AW-1:0];
        wdata_d = req_wdata;
        hi_d = 8'h00;
        rd_d = 1'b0;
        err_d = bad;
        cnt_d = 4'(WAIT_STATES - 1);
        state_d = bad ? RESP : (WAIT_STATES == 0 ? HI : WAIT);
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? HI : WAIT;
      end
      HI: state_d = LO;
      LO: begin
        // high byte read in HI is on the RAM output now; the low byte arrives as RESP opens
        hi_d = write_q ? 8'h00 : ram_rdata;
        rd_d = !write_q;
        state_d = RESP;
      end
      RESP: if (resp_ready) begin
        hi_d = 8'h00;
        rd_d = 1'b0;
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // one bubble after RESP before accepting again
    ready_d = state_q == IDLE && state_d == IDLE;
    valid_d = state_d == RESP;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      hi_q <= '0;
      rd_q <= 1'b0;
      err_q <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      hi_q <= hi_d;
      rd_q <= rd_d;
      err_q <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end
  // RAM stays on addr+1 with no write through RESP, so its registered output holds the low byte
  assign ram_we = write_q && (state_q == HI || state_q == LO);
  assign ram_addr = state_q == HI ? addr_q : addr_q + AW'(1);
  assign ram_wdata = state_q == HI ? wdata_q[15:8] : wdata_q[7:0];
  byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clock(clock),
    .we(ram_we),
    .addr(ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );
  assign req_ready = ready_q;
  assign resp_valid = valid_q;
  assign resp_error = err_q;
  assign resp_rdata = {hi_q, rd_q ? ram_rdata : 8'h00};
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against a byte-array model
module tb_mem_responder;
  localparam int W = 1;
  logic clock = 0, reset_n = 0;
  logic req_valid = 0, req_write = 0, resp_ready = 1;
  logic [15:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_error;
  logic [15:0] resp_rdata;
  mem_responder #(.DEPTH(16384), .WAIT_STATES(W)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error)
  );
  always #5 clock = ~clock;
  typedef struct {logic [15:0] rdata; logic err; int lat; int acc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] mem_m [int];
  int wa[$];
  int cycle = 0, n_cmp = 0, n_bad = 0, acc_cycle = 0;
  logic prev_v = 0;
  always @(posedge clock) cycle++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask
  always @(negedge clock) begin
    if (!reset_n) prev_v = 0;
    else begin
      if (resp_valid && !prev_v) begin
        if (sb.size() == 0) check("unexpected_resp", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("rdata", resp_rdata, mon_e.rdata);
          check("error", resp_error, mon_e.err);
          check("latency", cycle - mon_e.acc, mon_e.lat);
        end
      end
      prev_v = resp_valid;
    end
  end
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int i;
    @(negedge clock);
    for (i = 0; i < 100 && !req_ready; i++) @(negedge clock);
    if (!req_ready) check("req_ready_timeout", 0, 1);
    if (a[0] || a > 16'h3FFE) begin
      e.rdata = 0; e.err = 1; e.lat = 1;
    end else if (w) begin
      mem_m[a] = d[15:8]; mem_m[a + 1] = d[7:0];
      e.rdata = 0; e.err = 0; e.lat = W + 3;
    end else begin
      e.rdata = {mem_m[a], mem_m[a + 1]}; e.err = 0; e.lat = W + 3;
    end
    e.acc = cycle;
    acc_cycle = cycle;
    sb.push_back(e);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clock);
    req_valid = 0; req_write = $urandom_range(0, 1); req_addr = 16'($urandom); req_wdata = 16'($urandom);
  endtask
  task automatic wait_done(input bit rnd);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (i > 0) @(negedge clock);
      if (rnd) resp_ready = 1'($urandom_range(0, 1));
      if (resp_valid && resp_ready) done = 1;
    end
    if (!done) check("resp_timeout", 0, 1);
    @(negedge clock);
    resp_ready = 1;
  endtask
  task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d, input bit rnd);
    issue(w, a, d);
    wait_done(rnd);
  endtask
  logic [15:0] sv_rdata;
  logic sv_err;
  initial begin
    req_valid = 1; req_write = 1; req_addr = 16'h0010; req_wdata = 16'hDEAD;
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_error", resp_error, 0);
    reset_n = 1;
    @(negedge clock);
    check("ready_after_release", req_ready, 1);
    req_valid = 0;
    repeat (3) @(negedge clock);
    check("no_accept_in_reset", resp_valid, 0);
    txn(1, 16'h0010, 16'h1234, 0);
    txn(0, 16'h0010, 16'h0000, 0);
    txn(0, 16'h0011, 16'h0000, 0);
    txn(0, 16'h4000, 16'h0000, 0);
    txn(1, 16'h0011, 16'hFFFF, 0);
    txn(1, 16'hFFFE, 16'hFFFF, 0);
    txn(0, 16'h0010, 16'h0000, 0);
    txn(1, 16'h3FFE, 16'hBEEF, 0);
    txn(0, 16'h3FFE, 16'h0000, 0);
    resp_ready = 0;
    issue(0, 16'h3FFE, 16'h0000);
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clock);
    check("stall_valid", resp_valid, 1);
    sv_rdata = resp_rdata; sv_err = resp_error;
    check("stall_rdata0", sv_rdata, 16'hBEEF);
    repeat (5) begin
      @(negedge clock);
      check("stall_hold_valid", resp_valid, 1);
      check("stall_hold_rdata", resp_rdata, sv_rdata);
      check("stall_hold_error", resp_error, sv_err);
      check("stall_req_ready", req_ready, 0);
    end
    resp_ready = 1;
    @(negedge clock);
    check("stall_release", resp_valid, 0);
    txn(1, 16'h0020, 16'h0000, 0);
    txn(0, 16'h0020, 16'h0000, 0);
    issue(1, 16'h0020, 16'hAA55);
    repeat (W + 1) @(negedge clock);
    sb.delete();
    reset_n = 0;
    mem_m[16'h0021] = 8'h00;
    #1;
    check("lo_rst_req_ready", req_ready, 0);
    check("lo_rst_resp_valid", resp_valid, 0);
    check("lo_rst_rdata", resp_rdata, 0);
    check("lo_rst_error", resp_error, 0);
    @(negedge clock);
    reset_n = 1;
    txn(0, 16'h0020, 16'h0000, 0);
    wa.push_back(16'h0010); wa.push_back(16'h0020); wa.push_back(16'h3FFE);
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        a = r == 0 ? 16'($urandom_range(0, 32767) * 2 + 1) : 16'($urandom_range(16'h4000, 16'hFFFF));
        txn($urandom_range(0, 1), a, 16'($urandom), 1);
      end else if (r < 6) begin
        a = 16'($urandom_range(0, 8191) * 2);
        wa.push_back(a);
        txn(1, a, 16'($urandom), 1);
      end else begin
        a = 16'(wa[$urandom_range(0, wa.size() - 1)]);
        txn(0, a, 16'h0000, 1);
      end
    end
    repeat (10) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the accumulator machine's instruction/data memory port. It accepts 16-bit word read/write requests from the control unit over a valid/ready handshake. Each word is stored big-endian across two bytes of a 16Ki x 8 byte array, one byte per cycle, after a configurable number of wait states. The block returns one response per request, carrying read data and an error flag, over a second valid/ready handshake.

## Interface

- DEPTH, 16384, byte array size; legal byte addresses are 0..DEPTH-1.
- WAIT_STATES, 1, idle cycles inserted between request acceptance and the first byte access (0..15).
- clock  input  1  single clock; all logic is on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- req_valid  input  1  request present.
- req_ready  output  1  the responder can accept a request; reset value 0.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  16  byte address of the word's high byte.
- req_wdata  input  16  write data; [15:8] goes to addr and [7:0] goes to addr+1.
- resp_valid  output  1  response present; reset value 0.
- resp_ready  input  1  the requester accepts the response.
- resp_rdata  output  16  read data; 0 for writes and errors; reset value 0.
- resp_error  output  1  the request was rejected (misaligned or out of range); reset value 0.

## Operation

- States:
  - IDLE: req_ready=1.
  - WAIT: counts WAIT_STATES cycles.
  - HI: accesses byte addr.
  - LO: accesses byte addr+1.
  - RESP: resp_valid=1.
- Request acceptance: a request is accepted on a rising edge where req_valid && req_ready.
  - req_write, req_addr and req_wdata are captured into internal registers at acceptance.
  - Later changes on those inputs are ignored until the next acceptance.
- Error check, made at acceptance:
  - req_addr[0]=1 is misaligned.
  - req_addr > DEPTH-2 is out of range.
  - On error: next state is RESP with resp_error=1 and resp_rdata=0, and memory is untouched.
- Normal path: IDLE → WAIT (skipped when WAIT_STATES=0) → HI → LO → RESP.
- Write:
  - HI writes req_wdata[15:8] to byte addr.
  - LO writes req_wdata[7:0] to byte addr+1.
  - The response is an acknowledge: rdata=0, error=0.
- Read:
  - HI reads byte addr into rdata[15:8].
  - LO reads byte addr+1 into rdata[7:0].
  - The response is rdata with error=0.
- RESP:
  - resp_valid, resp_rdata and resp_error hold stable until resp_ready=1.
  - On that edge the state goes to IDLE and resp_valid drops.
- The block holds one outstanding request at most. req_ready=0 in every state except IDLE.
- Reset (reset_n low, at any time):
  - State goes to IDLE and the wait counter clears.
  - All outputs take their reset values; req_ready is 0 while reset is asserted.
  - Byte array contents are not cleared.
  - A write interrupted after HI leaves the high byte updated and the low byte old.
- Synchronous behaviour after reset release: req_ready rises on the first rising edge after reset_n goes high, once the state is IDLE.

## Timing

- Cycle 0 is the acceptance cycle (handshake sampled at the end of cycle 0).
- Normal request timing:
  - Cycles 1..W are WAIT, where W = WAIT_STATES.
  - Cycle W+1 is HI and cycle W+2 is LO.
  - resp_valid is high from cycle W+3.
- Error request: resp_valid is high in cycle 1.
- Write data is visible in the array from the cycle after LO.
- Read data is registered; resp_rdata is valid whenever resp_valid=1.
- Back-to-back throughput: RESP → IDLE costs one bubble cycle. Minimum request spacing is W+5 cycles when resp_ready is held high.
- WAIT counter: 4 bits, loaded with WAIT_STATES-1 on entry, and it leaves WAIT when it reaches 0.
- req_ready and the response outputs are driven from registers, with no combinational input-to-output paths.

## Structure

- Shared package mem_pkg:
  - state enum {IDLE, WAIT, HI, LO, RESP}.
  - Constant WORD_BYTES=2.
  - Constant default MEM_DEPTH=16384.
- Sub-module byte_ram: single-port synchronous 8-bit RAM, DEPTH entries, inputs we/addr/wdata, registered rdata.
  - It is instantiated once.
  - Byte selection (addr vs addr+1) is muxed in mem_responder.

## Test plan

1. Reset with req_valid=1 held: req_ready=0 and resp_valid=0 during reset, req_ready=1 one edge after release, and no request is accepted during reset.
2. With WAIT_STATES=1, write 0x1234 to 0x0010, then read 0x0010:
   - Write ack arrives in cycle 4 with error=0.
   - Byte 0x10 holds 0x12 and byte 0x11 holds 0x34.
   - The read returns rdata=0x1234 in cycle 4.
3. Read at 0x0011 and at 0x4000: resp_error=1 and rdata=0 in cycle 1, and array contents are unchanged.
4. Boundary read at 0x3FFE after writing 0xBEEF there: rdata=0xBEEF with error=0.
5. Hold resp_ready=0 for 5 cycles during a read response: resp_valid, rdata and error are stable, req_ready stays 0, and the response completes on the first resp_ready=1 edge.
6. Byte 0x20 and byte 0x21 are preloaded so that a read of 0x0020 returns 0x0000. Write 0xAA55 to 0x0020 and assert reset_n low in the LO cycle:
   - Outputs take their reset values.
   - A subsequent read of 0x0020 returns 0xAA00.
